dpi_stream_feeder: RTL and testbench
====================================

// Module: dpi_stream_feeder
// PURPOSE
//  Upstream driver for the per-category DPI regex matcher bank. Accepts a byte-wide packet stream,
//  maps each packet's flow key to a 6-bit stream id via a 64-entry CAM, and sequences the matcher
//  interface: load_state/new_stream_id, then chars, then an eop pulse.
//  One instance feeds all matcher instances in parallel. Per-category enables come from a config mask.
// PARAMETERS
//  KEY_W      32  flow key width (hashed 5-tuple supplied with the packet)
//  NUM_CAT    16  number of matcher categories (width of enable)
//  LOAD_GAP   2   cycles from load_state pulse to first char_in_vld (covers matcher state restore pipe)
//  DRAIN_GAP  3   cycles from last char_in_vld to eop (covers matcher char/state/accept registers)
// PORTS
//  clk            in   1       clock
//  rst            in   1       synchronous reset, active-high
//  pkt_data       in   8       packet byte
//  pkt_vld        in   1       byte valid; transfer when pkt_vld & pkt_rdy
//  pkt_sop        in   1       first byte of packet; pkt_key/pkt_fin valid on this beat
//  pkt_eop        in   1       last byte of packet
//  pkt_key        in   KEY_W   flow key
//  pkt_fin        in   1       flow terminates after this packet; release stream id at eop
//  pkt_rdy        out  1       byte accepted
//  cfg_en_mask    in   NUM_CAT category enable mask, sampled on the SOP beat
//  load_state     out  1       1-cycle pulse: matchers restore/reset state for stream_id
//  new_stream_id  out  1       valid with load_state: stream unseen, matchers start from state 0
//  stream_id      out  6       stream id, stable from load_state through eop
//  char_in        out  8       byte to matchers
//  char_in_vld    out  1       char_in valid
//  eop            out  1       1-cycle pulse: matchers commit count and save state
//  enable         out  NUM_CAT per-category enable, stable from load_state through eop
//  busy           out  1       FSM not in IDLE
//  stat_new       out  16      count of allocations (new_stream_id pulses), wraps
//  stat_evict     out  16      count of evictions (CAM full on allocation), wraps
//  stat_err       out  16      count of protocol errors, wraps
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; CAM all invalid; rr pointer=0; stats=0. Reset mid-packet aborts:
//   no eop issued; upstream must restart at SOP.
//  FSM: IDLE -> LOOKUP -> LOAD -> GAP -> STREAM -> DRAIN -> EOP -> IDLE.
//  IDLE: pkt_rdy=0. On pkt_vld&pkt_sop latch key, fin, cfg_en_mask; -> LOOKUP. pkt_vld without sop:
//   pkt_rdy=1 to drop beat, stat_err++.
//  LOOKUP (1 cycle): parallel compare over 64 valid entries. Hit -> id=hit index, new=0.
//   Miss -> lowest-index free entry; none free -> entry at rr pointer (evicted), rr ptr++ mod 64,
//   stat_evict++. Miss writes key, sets valid, new=1, stat_new++.
//  LOAD (1 cycle): load_state=1, new_stream_id=new, stream_id/enable driven (held until EOP exits).
//  GAP: LOAD_GAP-1 idle cycles, so first char_in_vld is exactly LOAD_GAP cycles after load_state.
//  STREAM: pkt_rdy=1; each accepted beat -> char_in=pkt_data, char_in_vld=1 next cycle (1-cycle
//   latency, order preserved, pkt_vld gaps give char_in_vld gaps). SOP beat is char 0.
//   sop seen in STREAM: stat_err++, treat as eop of current packet then drop beat.
//   Accepted beat with pkt_eop -> DRAIN, pkt_rdy=0.
//  DRAIN: eop asserted exactly DRAIN_GAP cycles after last char_in_vld.
//  EOP (1 cycle): eop=1; if fin latched, clear CAM valid for stream_id. Next load_state is at least
//   2 cycles after eop (IDLE+LOOKUP), satisfying matcher save-before-restore.
//  Same-packet hit and fin on one key: entry freed at eop; next packet with that key allocates anew.
//  Minimum packet 1 byte (sop&eop same beat). Stats saturate-free, wrap at 2^16.
// STRUCTURE
//  Package dpi_pkg: STREAM_ID_W=6, NUM_STREAMS=64, feeder FSM state enum, stat width.
//  Sub-module dpi_stream_cam: 64xKEY_W key regs + valid bits, 1-cycle lookup (hit, hit_idx,
//   free_avail, free_idx), write and invalidate ports, rr eviction pointer. FSM/datapath in top.
// TESTING
//  1 After rst, pkt key=0xA, 4 bytes "GET " -> load_state@T, new_stream_id=1, stream_id=0,
//    char_in_vld T+2..T+5 with G,E,T,space, eop@T+8, stat_new=1.
//  2 Second pkt key=0xA -> new_stream_id=0, stream_id=0; key=0xB -> new_stream_id=1, stream_id=1.
//  3 64 distinct keys then 65th -> stream_id=0 (evict), new_stream_id=1, stat_evict=1; 66th -> id 1.
//  4 Pkt key=0xC with pkt_fin=1 on id 2 -> after eop entry freed; next new key 0xD gets id 2.
//  5 pkt_vld toggling 1/0 during 8-byte pkt -> char_in order intact, gaps mirrored, single eop.
//  6 rst asserted mid-STREAM -> next cycle all outputs 0, no eop; repeat key 0xA -> new_stream_id=1;
//    beat without sop in IDLE -> dropped, stat_err=1.

Source files
------------

// File: rtl/dpi_pkg.sv
// rtl/dpi_pkg.sv - shared widths, stream id type and feeder FSM states for the DPI stream feeder
package dpi_pkg;
  localparam int STREAM_ID_W = 6;
  localparam int NUM_STREAMS = 64;
  localparam int STAT_W      = 16;

  typedef logic [STREAM_ID_W-1:0] stream_id_t;
  typedef logic [STAT_W-1:0]      stat_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_LOAD,
    ST_GAP,
    ST_STREAM,
    ST_DRAIN,
    ST_EOP
  } feeder_state_e;
endpackage

// File: rtl/dpi_stream_feeder_if.sv
// rtl/dpi_stream_feeder_if.sv - packet input stream and matcher-side sequencing bus
interface dpi_stream_feeder_if #(
  parameter int KEY_W   = 32,
  parameter int NUM_CAT = 16
);
  import dpi_pkg::*;

  logic [7:0]         pkt_data;
  logic               pkt_vld;
  logic               pkt_sop;
  logic               pkt_eop;
  logic [KEY_W-1:0]   pkt_key;
  logic               pkt_fin;
  logic               pkt_rdy;
  logic [NUM_CAT-1:0] cfg_en_mask;

  logic               load_state;
  logic               new_stream_id;
  stream_id_t         stream_id;
  logic [7:0]         char_in;
  logic               char_in_vld;
  logic               eop;
  logic [NUM_CAT-1:0] enable;

  modport master (
    output pkt_data, pkt_vld, pkt_sop, pkt_eop, pkt_key, pkt_fin, cfg_en_mask,
    input  pkt_rdy, load_state, new_stream_id, stream_id, char_in, char_in_vld, eop, enable
  );

  modport slave (
    input  pkt_data, pkt_vld, pkt_sop, pkt_eop, pkt_key, pkt_fin, cfg_en_mask,
    output pkt_rdy, load_state, new_stream_id, stream_id, char_in, char_in_vld, eop, enable
  );
endinterface

// File: rtl/dpi_stream_cam.sv
// rtl/dpi_stream_cam.sv - 64-entry flow key CAM with lowest-free search and round-robin victim pointer
module dpi_stream_cam
  import dpi_pkg::*;
#(
  parameter int KEY_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] lookup_key,
  output logic             hit,
  output stream_id_t       hit_idx,
  output logic             free_avail,
  output stream_id_t       free_idx,
  output stream_id_t       rr_idx,
  input  logic             wr_en,
  input  stream_id_t       wr_idx,
  input  logic [KEY_W-1:0] wr_key,
  input  logic             rr_adv,
  input  logic             inv_en,
  input  stream_id_t       inv_idx
);
  logic [KEY_W-1:0]       keys [NUM_STREAMS];
  logic [NUM_STREAMS-1:0] valid;
  stream_id_t             rr_ptr;

  // Descending scan so the lowest matching / free index wins.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_avail = 1'b0;
    free_idx   = '0;
    for (int i = NUM_STREAMS - 1; i >= 0; i--) begin
      if (valid[i] && (keys[i] == lookup_key)) begin
        hit     = 1'b1;
        hit_idx = stream_id_t'(i);
      end
      if (!valid[i]) begin
        free_avail = 1'b1;
        free_idx   = stream_id_t'(i);
      end
    end
  end

  assign rr_idx = rr_ptr;

  always_ff @(posedge clk) begin
    if (wr_en) keys[wr_idx] <= wr_key;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid  <= '0;
      rr_ptr <= '0;
    end else begin
      if (inv_en) valid[inv_idx] <= 1'b0;
      if (wr_en)  valid[wr_idx]  <= 1'b1;
      if (rr_adv) rr_ptr         <= rr_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/dpi_stream_feeder.sv
// rtl/dpi_stream_feeder.sv - maps packets to stream ids and sequences load/chars/eop for the matcher bank
module dpi_stream_feeder
  import dpi_pkg::*;
#(
  parameter int KEY_W     = 32,
  parameter int NUM_CAT   = 16,
  parameter int LOAD_GAP  = 2,
  parameter int DRAIN_GAP = 3
) (
  input  logic                clk,
  input  logic                rst,
  dpi_stream_feeder_if.slave  bus,
  output logic                busy,
  output stat_t               stat_new,
  output stat_t               stat_evict,
  output stat_t               stat_err
);
  // First accepted beat lands one cycle after pkt_rdy rises, so GAP holds LOAD_GAP-2 cycles.
  localparam logic [7:0] GAP_INIT   = (LOAD_GAP > 2) ? 8'(LOAD_GAP - 3) : 8'd0;
  localparam logic [7:0] DRAIN_INIT = 8'(DRAIN_GAP - 1);

  feeder_state_e      state, state_d;
  logic [KEY_W-1:0]   key_q;
  logic               fin_q, new_q, first_q;
  logic [NUM_CAT-1:0] en_q;
  stream_id_t         sid_q, alloc_idx;
  logic [7:0]         cnt_q, char_q;
  logic               char_vld_q;
  logic               pkt_rdy, take, sop_err, idle_drop, alloc;
  logic               cam_hit, cam_free;
  stream_id_t         cam_hit_idx, cam_free_idx, cam_rr_idx;

  always_comb begin
    state_d   = state;
    pkt_rdy   = 1'b0;
    take      = 1'b0;
    sop_err   = 1'b0;
    idle_drop = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.pkt_vld) begin
          if (bus.pkt_sop) state_d = ST_LOOKUP;
          else begin
            pkt_rdy   = 1'b1;
            idle_drop = 1'b1;
          end
        end
      end
      ST_LOOKUP: state_d = ST_LOAD;
      ST_LOAD:   state_d = (LOAD_GAP > 2) ? ST_GAP : ST_STREAM;
      ST_GAP:    if (cnt_q == 8'd0) state_d = ST_STREAM;
      ST_STREAM: begin
        pkt_rdy = 1'b1;
        if (bus.pkt_vld) begin
          // A fresh sop closes the current packet; the offending beat is discarded.
          if (bus.pkt_sop && !first_q) begin
            sop_err = 1'b1;
            state_d = ST_DRAIN;
          end else begin
            take = 1'b1;
            if (bus.pkt_eop) state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN:  if (cnt_q == 8'd0) state_d = ST_EOP;
      ST_EOP:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign alloc     = (state == ST_LOOKUP) && !cam_hit;
  assign alloc_idx = cam_free ? cam_free_idx : cam_rr_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      key_q      <= '0;
      fin_q      <= 1'b0;
      new_q      <= 1'b0;
      first_q    <= 1'b0;
      en_q       <= '0;
      sid_q      <= '0;
      cnt_q      <= '0;
      char_q     <= '0;
      char_vld_q <= 1'b0;
      stat_new   <= '0;
      stat_evict <= '0;
      stat_err   <= '0;
    end else begin
      state      <= state_d;
      char_vld_q <= take;
      if (take) begin
        char_q  <= bus.pkt_data;
        first_q <= 1'b0;
      end
      if (state == ST_IDLE && bus.pkt_vld && bus.pkt_sop) begin
        key_q <= bus.pkt_key;
        fin_q <= bus.pkt_fin;
        en_q  <= bus.cfg_en_mask;
      end
      if (state == ST_LOOKUP) begin
        sid_q <= cam_hit ? cam_hit_idx : alloc_idx;
        new_q <= !cam_hit;
      end
      if (state == ST_LOAD) begin
        first_q <= 1'b1;
        cnt_q   <= GAP_INIT;
      end
      if (state == ST_GAP || state == ST_DRAIN) cnt_q <= cnt_q - 8'd1;
      if (state == ST_STREAM && state_d == ST_DRAIN) cnt_q <= DRAIN_INIT;
      if (alloc) stat_new <= stat_new + 1'b1;
      if (alloc && !cam_free) stat_evict <= stat_evict + 1'b1;
      if (idle_drop || sop_err) stat_err <= stat_err + 1'b1;
    end
  end

  dpi_stream_cam #(.KEY_W(KEY_W)) u_cam (
    .clk        (clk),
    .rst        (rst),
    .lookup_key (key_q),
    .hit        (cam_hit),
    .hit_idx    (cam_hit_idx),
    .free_avail (cam_free),
    .free_idx   (cam_free_idx),
    .rr_idx     (cam_rr_idx),
    .wr_en      (alloc),
    .wr_idx     (alloc_idx),
    .wr_key     (key_q),
    .rr_adv     (alloc && !cam_free),
    .inv_en     ((state == ST_EOP) && fin_q),
    .inv_idx    (sid_q)
  );

  assign bus.pkt_rdy       = pkt_rdy;
  assign bus.load_state    = (state == ST_LOAD);
  assign bus.new_stream_id = (state == ST_LOAD) && new_q;
  assign bus.stream_id     = sid_q;
  assign bus.char_in       = char_q;
  assign bus.char_in_vld   = char_vld_q;
  assign bus.eop           = (state == ST_EOP);
  assign bus.enable        = en_q;
  assign busy              = (state != ST_IDLE);
endmodule

// File: tb/tb_dpi_stream_feeder.sv
// tb/tb_dpi_stream_feeder.sv - directed self-checking bench for dpi_stream_feeder
module tb_dpi_stream_feeder;
  import dpi_pkg::*;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  busy;
  stat_t stat_new, stat_evict, stat_err;

  dpi_stream_feeder_if #(.KEY_W(32), .NUM_CAT(16)) bus ();

  dpi_stream_feeder #(.KEY_W(32), .NUM_CAT(16), .LOAD_GAP(2), .DRAIN_GAP(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .busy       (busy),
    .stat_new   (stat_new),
    .stat_evict (stat_evict),
    .stat_err   (stat_err)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         passes = 0;
  int         cyc = 0;
  int         t_load = -1;
  int         t_eop = -1;
  int         eops = 0;
  logic       last_new = 1'b0;
  logic [5:0] last_sid = '0;
  logic [15:0] last_en = '0;
  logic [7:0] chars [$];
  int         char_t [$];
  logic [7:0] pkt_bytes [16];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.load_state) begin
      t_load   <= cyc;
      last_new <= bus.new_stream_id;
      last_sid <= bus.stream_id;
      last_en  <= bus.enable;
    end
    if (bus.char_in_vld) begin
      chars.push_back(bus.char_in);
      char_t.push_back(cyc);
    end
    if (bus.eop) begin
      eops  <= eops + 1;
      t_eop <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic drive_beat(input int i, input int len, input logic [31:0] key, input logic fin);
    bus.pkt_vld  = 1'b1;
    bus.pkt_data = pkt_bytes[i];
    bus.pkt_sop  = (i == 0);
    bus.pkt_eop  = (i == len - 1);
    bus.pkt_key  = key;
    bus.pkt_fin  = fin;
  endtask

  // stop_at < len asserts rst right after that many beats have been accepted.
  task automatic send_pkt(input logic [31:0] key, input logic fin, input int len,
                          input bit toggle, input int stop_at);
    int idx = 0;
    int guard = 0;
    bit xfer;
    @(posedge clk); #1;
    drive_beat(0, len, key, fin);
    while (idx < len && guard < 300) begin
      @(negedge clk);
      xfer = bus.pkt_vld && bus.pkt_rdy;
      @(posedge clk); #1;
      guard++;
      if (xfer) begin
        idx++;
        if (idx == stop_at) begin
          rst = 1'b1;
          break;
        end
        if (idx >= len || toggle) bus.pkt_vld = 1'b0;
        else drive_beat(idx, len, key, fin);
      end else if (!bus.pkt_vld) begin
        drive_beat(idx, len, key, fin);
      end
    end
    bus.pkt_vld = 1'b0;
    bus.pkt_sop = 1'b0;
    bus.pkt_eop = 1'b0;
    check("beats_accepted", idx, (stop_at < len) ? stop_at : len);
  endtask

  task automatic wait_eop(input int target);
    int guard = 0;
    while (eops < target && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("eop_seen", eops, target);
    @(negedge clk);
  endtask

  task automatic one_pkt(input logic [31:0] key, input logic fin);
    int e0 = eops;
    pkt_bytes[0] = 8'h5A;
    send_pkt(key, fin, 1, 1'b0, 99);
    wait_eop(e0 + 1);
  endtask

  int base, e0;

  initial begin
    bus.pkt_vld = 0; bus.pkt_sop = 0; bus.pkt_eop = 0; bus.pkt_data = '0;
    bus.pkt_key = '0; bus.pkt_fin = 0; bus.cfg_en_mask = 16'hA5A5;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_load_state", bus.load_state, 0);
    check("rst_char_vld", bus.char_in_vld, 0);
    check("rst_eop", bus.eop, 0);
    check("rst_busy", busy, 0);
    check("rst_pkt_rdy", bus.pkt_rdy, 0);
    check("rst_stats", {stat_new, stat_evict}, 0);

    // "GET " on key 0xA: fresh stream 0, exact load/char/eop timing
    pkt_bytes[0] = "G"; pkt_bytes[1] = "E"; pkt_bytes[2] = "T"; pkt_bytes[3] = " ";
    base = chars.size();
    send_pkt(32'hA, 1'b0, 4, 1'b0, 99);
    wait_eop(1);
    check("t1_new", last_new, 1);
    check("t1_sid", last_sid, 0);
    check("t1_enable", last_en, 16'hA5A5);
    check("t1_nchars", chars.size() - base, 4);
    for (int k = 0; k < 4; k++) begin
      check("t1_char", chars[base+k], pkt_bytes[k]);
      check("t1_char_time", char_t[base+k] - t_load, 2 + k);
    end
    check("t1_eop_time", t_eop - t_load, 8);
    check("t1_stat_new", stat_new, 1);

    // repeat key hits, new key allocates the next free id
    bus.cfg_en_mask = 16'h0F0F;
    one_pkt(32'hA, 1'b0);
    check("t2_hit_new", last_new, 0);
    check("t2_hit_sid", last_sid, 0);
    check("t2_enable", last_en, 16'h0F0F);
    one_pkt(32'hB, 1'b0);
    check("t2_miss_new", last_new, 1);
    check("t2_miss_sid", last_sid, 1);
    check("t2_stat_new", stat_new, 2);

    // fill the CAM, then two evictions in round-robin order
    for (int i = 0; i < 62; i++) one_pkt(32'h100 + i, 1'b0);
    check("t3_fill_sid", last_sid, 63);
    check("t3_fill_evict", stat_evict, 0);
    one_pkt(32'h200, 1'b0);
    check("t3_ev0_sid", last_sid, 0);
    check("t3_ev0_new", last_new, 1);
    check("t3_ev0_cnt", stat_evict, 1);
    one_pkt(32'h201, 1'b0);
    check("t3_ev1_sid", last_sid, 1);
    check("t3_ev1_cnt", stat_evict, 2);

    // fin releases the entry, next new key reuses it without evicting
    one_pkt(32'hC, 1'b1);
    check("t4_fin_sid", last_sid, 2);
    check("t4_evict", stat_evict, 3);
    one_pkt(32'hD, 1'b0);
    check("t4_reuse_sid", last_sid, 2);
    check("t4_reuse_new", last_new, 1);
    check("t4_no_evict", stat_evict, 3);
    check("t4_stat_new", stat_new, 68);

    // pkt_vld toggling: order intact, gaps mirrored, single eop
    for (int k = 0; k < 8; k++) pkt_bytes[k] = 8'h61 + 8'(k);
    base = chars.size();
    e0 = eops;
    send_pkt(32'hD, 1'b0, 8, 1'b1, 99);
    wait_eop(e0 + 1);
    check("t5_hit_sid", last_sid, 2);
    check("t5_nchars", chars.size() - base, 8);
    for (int k = 0; k < 8; k++) check("t5_char", chars[base+k], 8'h61 + 8'(k));
    for (int k = 0; k < 7; k++) check("t5_gap", char_t[base+k+1] - char_t[base+k], 2);
    check("t5_eop_time", t_eop - char_t[base+7], 3);
    repeat (5) @(negedge clk);
    check("t5_single_eop", eops, e0 + 1);

    // reset mid-STREAM aborts without eop and clears the CAM
    e0 = eops;
    send_pkt(32'hE, 1'b0, 8, 1'b0, 3);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t6_load_state", bus.load_state, 0);
    check("t6_char_vld", bus.char_in_vld, 0);
    check("t6_eop", bus.eop, 0);
    check("t6_busy", busy, 0);
    check("t6_sid", bus.stream_id, 0);
    check("t6_enable", bus.enable, 0);
    check("t6_stats", {stat_new, stat_evict}, 0);
    repeat (10) @(negedge clk);
    check("t6_no_eop", eops, e0);
    one_pkt(32'hA, 1'b0);
    check("t6_new", last_new, 1);
    check("t6_sid_after", last_sid, 0);
    check("t6_err0", stat_err, 0);

    // stray beat without sop in IDLE is dropped and counted
    base = chars.size();
    @(posedge clk); #1;
    bus.pkt_vld = 1'b1; bus.pkt_sop = 1'b0; bus.pkt_data = 8'hEE;
    @(negedge clk);
    check("t6_drop_rdy", bus.pkt_rdy, 1);
    @(posedge clk); #1;
    bus.pkt_vld = 1'b0;
    repeat (4) @(negedge clk);
    check("t6_err1", stat_err, 1);
    check("t6_drop_nochar", chars.size() - base, 0);
    check("t6_drop_idle", busy, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
